// File: rtl/cook_timer_pkg.sv
// Shared types and constants for the cook timer: FSM state encoding and BCD digit helpers.
package cook_timer_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t DIGIT_MAX     = 4'd9;
    localparam bcd_t SEC_TENS_WRAP = 4'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SET  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of a borrow-chained down counter; wraps to wrap_val when decremented from 0.
module bcd_down_digit
    import cook_timer_pkg::*;
(
    input  logic [3:0] val,
    input  logic       dec,
    input  logic [3:0] wrap_val,
    output logic [3:0] next_val,
    output logic       borrow_out
);

    always_comb begin
        next_val   = val;
        borrow_out = 1'b0;
        if (dec) begin
            if (val == 4'd0) begin
                next_val   = wrap_val;
                borrow_out = 1'b1;
            end else begin
                next_val = val - 4'd1;
            end
        end
    end

endmodule

// File: rtl/cook_timer.sv
// Microwave cook timer: keypad-entered MM:SS BCD time, counts down once per second while mag_on.
module cook_timer
    import cook_timer_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       clearn,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    input  logic       mag_on,
    output logic       timer_done,
    output logic       alarm,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones
);

    localparam int unsigned PW = $clog2(CLK_HZ);

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    bcd_t          mt_d, mo_d, st_d, so_d;
    bcd_t          mt_n, mo_n, st_n, so_n;
    logic          b_so, b_st, b_mo, b_mt;
    logic          entry_ok, run_en, tick, expire;

    assign entry_ok = digit_valid && !mag_on && (digit <= DIGIT_MAX);
    // The cycle that moves SET->RUN already counts toward the first second.
    assign run_en   = mag_on && ((state_q == SET) || (state_q == RUN));
    assign tick     = run_en && (presc_q == PW'(CLK_HZ - 1));

    bcd_down_digit u_sec_ones (.val(sec_ones), .dec(tick), .wrap_val(DIGIT_MAX),
                               .next_val(so_n), .borrow_out(b_so));
    bcd_down_digit u_sec_tens (.val(sec_tens), .dec(b_so), .wrap_val(SEC_TENS_WRAP),
                               .next_val(st_n), .borrow_out(b_st));
    bcd_down_digit u_min_ones (.val(min_ones), .dec(b_st), .wrap_val(DIGIT_MAX),
                               .next_val(mo_n), .borrow_out(b_mo));
    bcd_down_digit u_min_tens (.val(min_tens), .dec(b_mo), .wrap_val(DIGIT_MAX),
                               .next_val(mt_n), .borrow_out(b_mt));

    // A borrow out of min_tens would mean underflow; treat it as expiry too.
    assign expire = tick && (({mt_n, mo_n, st_n, so_n} == '0) || b_mt);

    always_comb begin
        mt_d    = min_tens;
        mo_d    = min_ones;
        st_d    = sec_tens;
        so_d    = sec_ones;
        presc_d = presc_q;
        state_d = state_q;
        if (!clearn) begin
            mt_d    = '0;
            mo_d    = '0;
            st_d    = '0;
            so_d    = '0;
            presc_d = '0;
            state_d = IDLE;
        end else if (entry_ok) begin
            mt_d    = min_ones;
            mo_d    = sec_tens;
            st_d    = sec_ones;
            so_d    = digit;
            state_d = ({min_ones, sec_tens, sec_ones, digit} != '0) ? SET : IDLE;
        end else if (tick) begin
            mt_d    = mt_n;
            mo_d    = mo_n;
            st_d    = st_n;
            so_d    = so_n;
            presc_d = '0;
            state_d = expire ? DONE : RUN;
        end else if (run_en) begin
            presc_d = presc_q + 1'b1;
            state_d = RUN;
        end else if (state_q == RUN) begin
            state_d = SET;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            min_tens   <= '0;
            min_ones   <= '0;
            sec_tens   <= '0;
            sec_ones   <= '0;
            timer_done <= 1'b1;
            alarm      <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            min_tens   <= mt_d;
            min_ones   <= mo_d;
            sec_tens   <= st_d;
            sec_ones   <= so_d;
            timer_done <= (state_d == IDLE) || (state_d == DONE);
            alarm      <= (state_d == DONE);
        end
    end

endmodule

// File: tb/tb_cook_timer.sv
// Self-checking bench for cook_timer using a seconds-level reference model of the display time.
module tb_cook_timer;

    localparam int HZ = 4;

    logic       clk = 1'b0;
    logic       rstn;
    logic       clearn;
    logic       digit_valid;
    logic [3:0] digit;
    logic       mag_on;
    logic       timer_done;
    logic       alarm;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;

    int checks = 0;
    int errors = 0;

    // Reference model: time as a 4-digit decimal number MMSS, counted cycles, expiry flag
    int m_val;
    int m_cnt;
    bit m_exp;

    localparam logic [17:0] RESET_VEC = {16'h0000, 1'b1, 1'b0};

    logic [17:0] act;
    assign act = {min_tens, min_ones, sec_tens, sec_ones, timer_done, alarm};

    cook_timer #(.CLK_HZ(HZ)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .clearn     (clearn),
        .digit_valid(digit_valid),
        .digit      (digit),
        .mag_on     (mag_on),
        .timer_done (timer_done),
        .alarm      (alarm),
        .min_tens   (min_tens),
        .min_ones   (min_ones),
        .sec_tens   (sec_tens),
        .sec_ones   (sec_ones)
    );

    always #5 clk = ~clk;

    function automatic int sec_dec(input int v);
        int mm, ss;
        mm = v / 100;
        ss = v % 100;
        if (ss == 0) begin
            mm = mm - 1;
            ss = 59;
        end else begin
            ss = ss - 1;
        end
        return mm * 100 + ss;
    endfunction

    function automatic logic [17:0] exp_vec();
        logic [3:0] a, b, c, d;
        a = 4'(m_val / 1000);
        b = 4'((m_val / 100) % 10);
        c = 4'((m_val / 10) % 10);
        d = 4'(m_val % 10);
        return {a, b, c, d, (m_val == 0), m_exp};
    endfunction

    task automatic m_reset();
        m_val = 0;
        m_cnt = 0;
        m_exp = 1'b0;
    endtask

    // Drive one cycle of inputs, advance a clock edge, update the model, settle 1 time unit.
    task automatic step(input logic c, input logic v, input logic [3:0] d, input logic m);
        clearn      = c;
        digit_valid = v;
        digit       = d;
        mag_on      = m;
        @(posedge clk);
        if (!c) begin
            m_reset();
        end else if (v && !m && d <= 4'd9) begin
            m_val = (m_val * 10 + int'(d)) % 10000;
            m_exp = 1'b0;
        end else if (m && m_val != 0) begin
            m_cnt++;
            if (m_cnt == HZ) begin
                m_cnt = 0;
                m_val = sec_dec(m_val);
                if (m_val == 0) m_exp = 1'b1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; clearn = 1'b1; digit_valid = 1'b0; digit = 4'd0; mag_on = 1'b0;
        m_reset();
        #12;
        checks++;
        if (act !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_values act=%h exp=%h", act, RESET_VEC);
        end
        rstn = 1'b1;
    endtask

    task automatic test_countdown();
        step(1, 1, 4'd1, 0);
        step(1, 1, 4'd3, 0);
        for (int i = 1; i <= 52; i++) begin
            step(1, 0, 4'd0, 1);
            checks++;
            if (act !== exp_vec()) begin
                errors++;
                $display("FAIL countdown_c%0d act=%h exp=%h", i, act, exp_vec());
            end
            if (i == 4) begin
                checks++;
                if (act !== {16'h0012, 1'b0, 1'b0}) begin
                    errors++;
                    $display("FAIL first_tick act=%h exp=%h", act, {16'h0012, 2'b00});
                end
            end
        end
        checks++;
        if (act !== {16'h0000, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL expiry act=%h exp=%h", act, {16'h0000, 2'b11});
        end
        step(1, 0, 4'd0, 0);
    endtask

    task automatic test_borrow();
        step(0, 0, 4'd0, 0);
        step(1, 1, 4'd1, 0);
        step(1, 1, 4'd0, 0);
        step(1, 1, 4'd0, 0);
        for (int i = 0; i < HZ; i++) step(1, 0, 4'd0, 1);
        checks++;
        if (act !== {16'h0059, 2'b00} || act !== exp_vec()) begin
            errors++;
            $display("FAIL minute_borrow act=%h exp=%h", act, {16'h0059, 2'b00});
        end
        step(0, 0, 4'd0, 0);
        step(1, 1, 4'd9, 0);
        step(1, 1, 4'd0, 0);
        for (int i = 0; i < HZ; i++) step(1, 0, 4'd0, 1);
        checks++;
        if (act !== {16'h0089, 2'b00} || act !== exp_vec()) begin
            errors++;
            $display("FAIL sec_tens_90 act=%h exp=%h", act, {16'h0089, 2'b00});
        end
    endtask

    task automatic test_pause();
        step(0, 0, 4'd0, 0);
        step(1, 1, 4'd0, 0);
        step(1, 1, 4'd5, 0);
        for (int i = 0; i < 6; i++) step(1, 0, 4'd0, 1);
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 4'd0, 0);
            checks++;
            if (act !== {16'h0004, 2'b00}) begin
                errors++;
                $display("FAIL pause_hold_c%0d act=%h exp=%h", i, act, {16'h0004, 2'b00});
            end
        end
        step(1, 0, 4'd0, 1);
        checks++;
        if (act !== {16'h0004, 2'b00}) begin
            errors++;
            $display("FAIL resume_partial act=%h exp=%h", act, {16'h0004, 2'b00});
        end
        step(1, 0, 4'd0, 1);
        checks++;
        if (act !== {16'h0003, 2'b00} || act !== exp_vec()) begin
            errors++;
            $display("FAIL resume_tick act=%h exp=%h", act, {16'h0003, 2'b00});
        end
        step(1, 0, 4'd0, 0);
    endtask

    task automatic test_ignored_inputs();
        step(0, 0, 4'd0, 0);
        step(1, 1, 4'd5, 0);
        step(1, 0, 4'd0, 1);
        step(1, 1, 4'd7, 1);
        checks++;
        if (act !== {16'h0005, 2'b00}) begin
            errors++;
            $display("FAIL digit_in_run act=%h exp=%h", act, {16'h0005, 2'b00});
        end
        step(0, 1, 4'd4, 1);
        checks++;
        if (act !== RESET_VEC) begin
            errors++;
            $display("FAIL clear_over_digit act=%h exp=%h", act, RESET_VEC);
        end
        step(1, 1, 4'd12, 0);
        checks++;
        if (act !== RESET_VEC) begin
            errors++;
            $display("FAIL digit_12_idle act=%h exp=%h", act, RESET_VEC);
        end
    endtask

    task automatic test_idle_and_done();
        for (int i = 0; i < 20; i++) step(1, 0, 4'd0, 1);
        checks++;
        if (act !== RESET_VEC) begin
            errors++;
            $display("FAIL idle_ignores_mag act=%h exp=%h", act, RESET_VEC);
        end
        step(1, 1, 4'd1, 0);
        for (int i = 0; i < HZ; i++) step(1, 0, 4'd0, 1);
        checks++;
        if (act !== {16'h0000, 2'b11}) begin
            errors++;
            $display("FAIL done_alarm act=%h exp=%h", act, {16'h0000, 2'b11});
        end
        for (int i = 0; i < 8; i++) step(1, 0, 4'd0, 1);
        checks++;
        if (act !== {16'h0000, 2'b11}) begin
            errors++;
            $display("FAIL done_ignores_mag act=%h exp=%h", act, {16'h0000, 2'b11});
        end
        step(1, 1, 4'd3, 0);
        checks++;
        if (act !== {16'h0003, 2'b00}) begin
            errors++;
            $display("FAIL entry_from_done act=%h exp=%h", act, {16'h0003, 2'b00});
        end
    endtask

    task automatic test_async_reset();
        step(1, 1, 4'd2, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 4'd0, 1);
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (act !== RESET_VEC) begin
            errors++;
            $display("FAIL async_reset act=%h exp=%h", act, RESET_VEC);
        end
        m_reset();
        mag_on = 1'b0;
        #2;
        rstn = 1'b1;
    endtask

    task automatic test_random();
        logic m;
        logic c, v;
        logic [3:0] d;
        m = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) m = ~m;
            c = ($urandom_range(0, 63) != 0);
            v = ($urandom_range(0, 5) == 0);
            d = 4'($urandom_range(0, 15));
            step(c, v, d, m);
            checks++;
            if (act !== exp_vec()) begin
                errors++;
                $display("FAIL random_c%0d act=%h exp=%h", i, act, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_borrow();
        test_pause();
        test_ignored_inputs();
        test_idle_and_done();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
